// File: rtl/snn_lif_step_core_if.sv
// Wishbone classic slave bus between the management SoC and the LIF neuron core.
interface snn_lif_step_core_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/snn_lif_step_core.sv
// Time-multiplexed leaky-integrate-and-fire core: one neuron at a time, one
// input per cycle, then a leak/saturate/threshold update per neuron.
module snn_lif_step_core #(
    parameter int N_NEURON = 4,
    parameter int N_INPUT  = 8,
    parameter int V_W      = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    snn_lif_step_core_if.slave  wb,
    output logic [N_NEURON-1:0] spike_o,
    output logic                busy_o,
    output logic                irq_o
);
    localparam int WW = N_INPUT * 4;
    localparam int AW = V_W + 4;
    localparam int TW = V_W + 6;
    localparam int IW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam logic signed [TW-1:0] VMAX = {{(TW-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
    localparam logic signed [TW-1:0] VMIN = {{(TW-V_W+1){1'b1}}, {(V_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_UPD, S_DONE} state_t;
    state_t state, state_nxt;

    logic [N_NEURON-1:0][WW-1:0]  weight;
    logic [N_NEURON-1:0][V_W-1:0] pot;
    logic [N_INPUT-1:0]           in_reg, in_snap;
    logic [15:0]                  thr_reg, thr_snap;
    logic [7:0]                   leak_reg, leak_snap;
    logic [15:0]                  step_cnt;
    logic                         done;
    logic [N_NEURON-1:0]          spike_nxt;
    logic signed [AW-1:0]         acc;
    logic [IW-1:0]                in_idx;
    logic [NW-1:0]                n_idx;

    logic [5:0]  reg_idx;
    logic [NW-1:0] ridx;
    logic        in_range, idle, req, wr_commit, start_go, clrv_go;
    logic [31:0] rdata, wm;
    logic        unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    assign reg_idx    = wb.wbs_adr_i[7:2];
    assign ridx       = reg_idx[NW-1:0];
    assign in_range   = (32'(reg_idx[2:0]) < N_NEURON);
    assign unused_adr = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};
    assign idle       = (state == S_IDLE);
    // New request: answered one cycle later; write side-effects land at the end of the ack cycle.
    assign req        = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
    assign wr_commit  = wb.wbs_cyc_i & wb.wbs_stb_i & wb.wbs_we_i & wb.wbs_ack_o;
    // Byte-enable merge against the register's current readable value.
    assign wm         = merge(rdata, wb.wbs_dat_i, wb.wbs_sel_i);
    assign start_go   = wr_commit && (reg_idx == 6'd0) && wm[0] && idle;
    assign clrv_go    = wr_commit && (reg_idx == 6'd0) && wm[1] && idle;

    // Register read mux (also supplies the old value for partial writes).
    always_comb begin
        rdata = '0;
        case (reg_idx)
            6'd1: rdata = {step_cnt, 14'd0, done, busy_o};
            6'd2: rdata[N_INPUT-1:0] = in_reg;
            6'd3: rdata = {8'd0, leak_reg, thr_reg};
            6'd4: rdata[N_NEURON-1:0] = spike_o;
            default: begin
                if (reg_idx[5:3] == 3'd1 && in_range)
                    rdata[WW-1:0] = weight[ridx];
                else if (reg_idx[5:3] == 3'd2 && in_range)
                    rdata = {{(32-V_W){pot[ridx][V_W-1]}}, pot[ridx]};
            end
        endcase
    end

    // Neuron update: integrate, leak toward zero, saturate, threshold.
    logic signed [TW-1:0] t_sum, t_lk, t_sat, leak_ext, thr_ext;
    logic                 fire;
    logic [3:0]           nib;
    always_comb begin
        nib      = weight[n_idx][{in_idx, 2'b00} +: 4];
        leak_ext = {{(TW-8){1'b0}}, leak_snap};
        thr_ext  = {{(TW-16){thr_snap[15]}}, thr_snap};
        t_sum    = {{(TW-V_W){pot[n_idx][V_W-1]}}, pot[n_idx]} + {{(TW-AW){acc[AW-1]}}, acc};
        t_lk     = '0;
        if (!t_sum[TW-1] && (|t_sum)) begin
            if (t_sum > leak_ext) t_lk = t_sum - leak_ext;
        end else if (t_sum[TW-1]) begin
            if (t_sum < -leak_ext) t_lk = t_sum + leak_ext;
        end
        t_sat = t_lk;
        if (t_lk > VMAX) t_sat = VMAX;
        else if (t_lk < VMIN) t_sat = VMIN;
        fire = (t_sat >= thr_ext);
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state: inputs serially per neuron, one update per neuron, then done.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_go) state_nxt = S_ACC;
            S_ACC:  if (in_idx == IW'(N_INPUT-1)) state_nxt = S_UPD;
            S_UPD:  state_nxt = (n_idx == NW'(N_NEURON-1)) ? S_DONE : S_ACC;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wishbone ack and read-data capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            if (req && !wb.wbs_we_i) wb.wbs_dat_o <= rdata;
        end
    end

    // Config registers, step sequencing and neuron state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            weight <= '0; pot <= '0; in_reg <= '0; in_snap <= '0;
            thr_reg <= '0; thr_snap <= '0; leak_reg <= '0; leak_snap <= '0;
            step_cnt <= '0; done <= 1'b0; spike_nxt <= '0; spike_o <= '0;
            acc <= '0; in_idx <= '0; n_idx <= '0; busy_o <= 1'b0; irq_o <= 1'b0;
        end else begin
            irq_o <= 1'b0;
            if (wr_commit && idle) begin
                case (reg_idx)
                    6'd2: in_reg <= wm[N_INPUT-1:0];
                    6'd3: begin thr_reg <= wm[15:0]; leak_reg <= wm[23:16]; end
                    default: if (reg_idx[5:3] == 3'd1 && in_range) weight[ridx] <= wm[WW-1:0];
                endcase
            end
            if (clrv_go) pot <= '0;
            if (start_go) begin
                in_snap <= in_reg; thr_snap <= thr_reg; leak_snap <= leak_reg;
                done <= 1'b0; busy_o <= 1'b1; acc <= '0;
                in_idx <= '0; n_idx <= '0; spike_nxt <= '0;
            end
            case (state)
                S_ACC: begin
                    if (in_snap[in_idx]) acc <= acc + {{V_W{nib[3]}}, nib};
                    in_idx <= (in_idx == IW'(N_INPUT-1)) ? '0 : in_idx + 1'b1;
                end
                S_UPD: begin
                    pot[n_idx]       <= fire ? '0 : t_sat[V_W-1:0];
                    spike_nxt[n_idx] <= fire;
                    acc   <= '0;
                    n_idx <= n_idx + 1'b1;
                end
                S_DONE: begin
                    spike_o  <= spike_nxt;
                    step_cnt <= step_cnt + 16'd1;
                    done     <= 1'b1;
                    irq_o    <= 1'b1;
                    busy_o   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_lif_step_core.sv
// Bench for snn_lif_step_core: register table, spec scenarios, random steps vs a model.
module tb_snn_lif_step_core;
    localparam int NN = 4, NI = 8, VW = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [NN-1:0] spike;
    logic busy, irq;

    snn_lif_step_core_if bus();
    snn_lif_step_core #(.N_NEURON(NN), .N_INPUT(NI), .V_W(VW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
        .spike_o(spike), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model state
    int          mv[NN];
    logic [31:0] mw[NN];
    logic [7:0]  m_in, m_leak;
    logic [15:0] m_thr;
    int          m_cnt;
    logic        m_done;
    logic [NN-1:0] m_spk;

    typedef struct {
        string       name;
        logic [31:0] wadr, wdat;
        logic [3:0]  sel;
        logic [31:0] radr, exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NN; n++) begin mv[n] = 0; mw[n] = '0; end
        m_in = '0; m_leak = '0; m_thr = '0; m_cnt = 0; m_done = 1'b0; m_spk = '0;
    endtask

    // One timestep from the rules: weighted sum, leak toward 0, clamp, threshold.
    task automatic model_step();
        int sum, t, w4, th, lk;
        th = int'($signed(m_thr));
        lk = int'(m_leak);
        for (int n = 0; n < NN; n++) begin
            sum = 0;
            for (int i = 0; i < NI; i++) begin
                w4 = int'((mw[n] >> (4*i)) & 32'hF);
                if (w4 > 7) w4 -= 16;
                if (m_in[i]) sum += w4;
            end
            t = mv[n] + sum;
            if (t > 0) t = (t > lk) ? t - lk : 0;
            else if (t < 0) t = (-t > lk) ? t + lk : 0;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            m_spk[n] = (t >= th);
            mv[n] = m_spk[n] ? 0 : t;
        end
        m_cnt = (m_cnt + 1) & 32'hFFFF;
        m_done = 1'b1;
    endtask

    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rd);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
        do begin @(posedge clk); #1; n++; end while (!bus.wbs_ack_o && n < 4);
        chk($sformatf("ack_latency@%02h", adr), n, 1);
        rd = bus.wbs_dat_o;
        @(posedge clk); #1;
        chk($sformatf("ack_once@%02h", adr), {31'd0, bus.wbs_ack_o}, 0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        bus_xfer(1'b1, adr, dat, 4'hF, d);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        bus_xfer(1'b0, adr, 32'h0, 4'hF, d);
    endtask

    // Idle-time write that the model also absorbs.
    task automatic mwr(input logic [31:0] adr, input logic [31:0] dat);
        wr(adr, dat);
        if (adr == 32'h00 && dat[1]) for (int n = 0; n < NN; n++) mv[n] = 0;
        if (adr == 32'h08) m_in = dat[7:0];
        if (adr == 32'h0C) begin m_thr = dat[15:0]; m_leak = dat[23:16]; end
        if (adr >= 32'h20 && adr < 32'h20 + 4*NN) mw[(adr - 32'h20) >> 2] = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic start_step();
        wr(32'h00, 32'h1);
        chk("busy_rise", {31'd0, busy}, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!irq && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("irq_seen", {31'd0, irq}, 1);
        chk("busy_fall_with_irq", {31'd0, busy}, 0);
        model_step();
        chk("spike_port", {28'd0, spike}, {28'd0, m_spk});
    endtask

    task automatic run_step(output int lat);
        start_step();
        wait_done(lat);
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] d;
        rd(32'h10, d); chk({tag, "_spikes"}, d, {28'd0, m_spk});
        rd(32'h04, d); chk({tag, "_status"}, d, {m_cnt[15:0], 14'd0, m_done, 1'b0});
        for (int n = 0; n < NN; n++) begin
            rd(32'h40 + 4*n, d);
            chk($sformatf("%s_pot%0d", tag, n), d, 32'(mv[n]));
        end
    endtask

    task automatic single_fire_setup();
        mwr(32'h0C, 32'd10);
        mwr(32'h20, 32'h33333333);
        mwr(32'h08, 32'h0F);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat, seen;
        logic [31:0] exp_pot[3];
        logic [31:0] exp_spk[3];

        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_ack", {31'd0, bus.wbs_ack_o}, 0);
        chk("rst_dat", bus.wbs_dat_o, 0);
        chk("rst_spike", {28'd0, spike}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        compare_all("reset");

        // Reset asserted while a read is being acknowledged
        wr(32'h08, 32'hFF);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h08;
        @(posedge clk); #1;
        chk("midbus_ack_before", {31'd0, bus.wbs_ack_o}, 1);
        chk("midbus_dat_before", bus.wbs_dat_o, 32'hFF);
        #2 rst = 1'b1;
        #1;
        chk("midbus_ack", {31'd0, bus.wbs_ack_o}, 0);
        chk("midbus_dat", bus.wbs_dat_o, 0);
        chk("midbus_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        rst = 1'b0;
        model_reset();
        rd(32'h08, d); chk("midbus_input_cleared", d, 0);

        // Register table
        tbl.push_back('{"input_full",  32'h08, 32'hFFFFFFFF, 4'hF, 32'h08, 32'h000000FF});
        tbl.push_back('{"param_full",  32'h0C, 32'h12345678, 4'hF, 32'h0C, 32'h00345678});
        tbl.push_back('{"param_byte0", 32'h0C, 32'hAAAAAAAA, 4'h1, 32'h0C, 32'h003456AA});
        tbl.push_back('{"w0_full",     32'h20, 32'hDEADBEEF, 4'hF, 32'h20, 32'hDEADBEEF});
        tbl.push_back('{"w1_hi",       32'h24, 32'h11223344, 4'hC, 32'h24, 32'h11220000});
        tbl.push_back('{"w1_byte1",    32'h24, 32'hFFFFFFFF, 4'h2, 32'h24, 32'h1122FF00});
        tbl.push_back('{"w3_full",     32'h2C, 32'hCAFEF00D, 4'hF, 32'h2C, 32'hCAFEF00D});
        tbl.push_back('{"w4_unmapped", 32'h30, 32'hFFFFFFFF, 4'hF, 32'h30, 32'h0});
        tbl.push_back('{"unmapped_14", 32'h14, 32'hFFFFFFFF, 4'hF, 32'h14, 32'h0});
        tbl.push_back('{"unmapped_80", 32'h80, 32'hFFFFFFFF, 4'hF, 32'h80, 32'h0});
        tbl.push_back('{"spikes_ro",   32'h10, 32'hFFFFFFFF, 4'hF, 32'h10, 32'h0});
        tbl.push_back('{"pot_ro",      32'h44, 32'hFFFFFFFF, 4'hF, 32'h44, 32'h0});
        tbl.push_back('{"status_ro",   32'h04, 32'hFFFFFFFF, 4'hF, 32'h04, 32'h0});
        tbl.push_back('{"ctrl_reads0", 32'h00, 32'h00000000, 4'hF, 32'h00, 32'h0});
        for (int k = 0; k < tbl.size(); k++) begin
            bus_xfer(1'b1, tbl[k].wadr, tbl[k].wdat, tbl[k].sel, d);
            rd(tbl[k].radr, d);
            chk(tbl[k].name, d, tbl[k].exp);
        end
        do_reset();

        // Single fire
        single_fire_setup();
        run_step(lat);
        chk("fire_latency", lat, 37);
        rd(32'h10, d); chk("fire_spikes", d, 32'h1);
        rd(32'h40, d); chk("fire_pot0", d, 32'h0);
        rd(32'h04, d); chk("fire_count", {16'd0, d[31:16]}, 32'd1);
        chk("fire_done", {31'd0, d[1]}, 1);
        compare_all("fire");

        // Integration without leak
        do_reset();
        mwr(32'h0C, 32'd10); mwr(32'h24, 32'h11111111); mwr(32'h08, 32'h0F);
        exp_pot = '{32'd4, 32'd8, 32'd0};
        exp_spk = '{32'h0, 32'h0, 32'h2};
        for (int k = 0; k < 3; k++) begin
            run_step(lat);
            rd(32'h44, d); chk($sformatf("integ_pot1_step%0d", k+1), d, exp_pot[k]);
            rd(32'h10, d); chk($sformatf("integ_spk_step%0d", k+1), d, exp_spk[k]);
        end
        compare_all("integ");

        // Leak cancels the input
        do_reset();
        mwr(32'h0C, 32'h0004000A); mwr(32'h24, 32'h11111111); mwr(32'h08, 32'h0F);
        for (int k = 0; k < 3; k++) begin
            run_step(lat);
            rd(32'h44, d); chk($sformatf("leak_pot1_step%0d", k+1), d, 32'h0);
            rd(32'h10, d); chk($sformatf("leak_spk_step%0d", k+1), d, 32'h0);
        end

        // Negative saturation
        do_reset();
        mwr(32'h0C, 32'd10); mwr(32'h28, 32'h88888888); mwr(32'h08, 32'hFF);
        repeat (600) run_step(lat);
        rd(32'h48, d); chk("negsat_pot2", d, 32'hFFFF8000);
        rd(32'h10, d); chk("negsat_spikes", d, 32'h0);
        compare_all("negsat");

        // Writes while busy are acked and dropped
        do_reset();
        single_fire_setup();
        start_step();
        wr(32'h00, 32'h1);
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h0);
        wait_done(lat);
        repeat (5) @(posedge clk); #1;
        chk("busyprot_idle", {31'd0, busy}, 0);
        rd(32'h10, d); chk("busyprot_spikes", d, 32'h1);
        rd(32'h08, d); chk("busyprot_input", d, 32'h0F);
        rd(32'h0C, d); chk("busyprot_param", d, 32'd10);
        compare_all("busyprot");

        // Reset in the middle of a step
        do_reset();
        single_fire_setup();
        start_step();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_irq", {31'd0, irq}, 0);
        chk("abort_spike", {28'd0, spike}, 0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (50) begin @(posedge clk); #1; if (irq || busy) seen = 1; end
        chk("abort_quiet", seen, 0);
        compare_all("abort");
        single_fire_setup();
        run_step(lat);
        chk("after_abort_latency", lat, 37);
        compare_all("after_abort");

        // Randomized steps against the model
        do_reset();
        for (int k = 0; k < 40; k++) begin
            for (int n = 0; n < NN; n++) if ($urandom_range(0, 2) == 0) mwr(32'h20 + 4*n, $urandom);
            mwr(32'h08, {24'd0, 8'($urandom)});
            mwr(32'h0C, {8'd0, 8'($urandom_range(0, 7)), 16'($urandom_range(0, 60) - 10)});
            if ($urandom_range(0, 4) == 0) mwr(32'h00, 32'h2);
            run_step(lat);
            chk("rand_latency", lat, 37);
            compare_all($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
